// File: rtl/elapsed_timer_pkg.sv
// ---------------------------------------------------------------------------
// elapsed_timer_pkg
// Shared types and constants for the elapsed timer:
//   state_t   - run-control FSM states
//   bcd_t     - one 4-bit BCD digit
//   SEC_T_MAX - highest seconds-tens digit value
//   DIGIT_MAX - highest decimal digit value
// ---------------------------------------------------------------------------
package elapsed_timer_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_PAUSE = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  typedef logic [3:0] bcd_t;

  localparam bcd_t SEC_T_MAX = 4'd5;
  localparam bcd_t DIGIT_MAX = 4'd9;

endpackage

// File: rtl/elapsed_timer_bcd_digit_counter.sv
// ---------------------------------------------------------------------------
// bcd_digit_counter
// One BCD digit that counts 0..modulus and wraps to 0.
//   clk, rst  - clock, asynchronous active-low reset
//   en        - increment request for this digit (carry-in)
//   hold      - suppresses the register update while en still drives
//               q_next/carry (used to freeze the whole chain on saturation)
//   clr       - synchronous clear to 0, wins over en
//   modulus   - highest digit value before wrap
//   q         - current digit
//   q_next    - value the digit takes on an unheld enable
//   carry     - carry-out: en while the digit is at modulus
// ---------------------------------------------------------------------------
module bcd_digit_counter
  import elapsed_timer_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic hold,
  input  logic clr,
  input  bcd_t modulus,
  output bcd_t q,
  output bcd_t q_next,
  output logic carry
);

  // A digit at or above its modulus wraps, so a stray value can never persist.
  assign carry  = en && (q >= modulus);
  assign q_next = !en ? q : (q >= modulus) ? '0 : bcd_t'(q + 4'd1);

  // NOTE: state registers use non-blocking assignment so every flop samples
  // the pre-edge values regardless of process evaluation order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)               q <= '0;
    else if (clr)           q <= '0;
    else if (en && !hold)   q <= q_next;
  end

endmodule

// File: rtl/elapsed_timer.sv
// ---------------------------------------------------------------------------
// elapsed_timer
// Stopwatch counting M:ST.SO.T in BCD with optional limit and best-time
// register.
//   clk, rst                 - clock, asynchronous active-low reset
//   tick_100ms               - one-cycle enable every 100 ms
//   start_p/pause_p/finish_p/clear_p - one-cycle commands
//                              (priority clear > finish > pause > start)
//   lim_min, lim_sec_t       - run limit sampled at start from IDLE; 0:00 = none
//   min_d, sec_t, sec_o, tenth - elapsed time
//   running, paused, done    - state decode
//   limit_flag               - run ended by limit or by saturation
//   best_*                   - lowest finish time; best_valid once loaded
//   new_best                 - one-cycle pulse coincident with a best update
// ---------------------------------------------------------------------------
module elapsed_timer
  import elapsed_timer_pkg::*;
#(
  parameter int unsigned MAX_MIN = 9
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick_100ms,
  input  logic       start_p,
  input  logic       pause_p,
  input  logic       finish_p,
  input  logic       clear_p,
  input  logic [3:0] lim_min,
  input  logic [2:0] lim_sec_t,
  output logic [3:0] min_d,
  output logic [3:0] sec_t,
  output logic [3:0] sec_o,
  output logic [3:0] tenth,
  output logic       running,
  output logic       paused,
  output logic       done,
  output logic       limit_flag,
  output logic [3:0] best_min,
  output logic [3:0] best_sec_t,
  output logic [3:0] best_sec_o,
  output logic [3:0] best_tenth,
  output logic       best_valid,
  output logic       new_best
);

  localparam bcd_t MIN_MOD = bcd_t'(MAX_MIN);

  state_t     state, state_n;
  logic [3:0] lim_min_q;
  logic [2:0] lim_sec_t_q;

  logic count_req, sat, limit_hit, lim_load, fin, limit_set, best_load;
  logic c_tenth, c_sec_o, c_sec_t, c_min;
  bcd_t n_tenth, n_sec_o, n_sec_t, n_min;

  // A tick only counts while running and not overridden by clear/finish.
  assign count_req = tick_100ms && (state == S_RUN) && !clear_p && !finish_p;

  // A carry out of the minute digit means the tick would wrap past
  // MAX_MIN:59.9; the whole chain holds instead.
  assign sat = c_min;

  bcd_digit_counter u_tenth (
    .clk(clk), .rst(rst), .en(count_req), .hold(sat), .clr(clear_p),
    .modulus(DIGIT_MAX), .q(tenth), .q_next(n_tenth), .carry(c_tenth)
  );
  bcd_digit_counter u_sec_o (
    .clk(clk), .rst(rst), .en(c_tenth), .hold(sat), .clr(clear_p),
    .modulus(DIGIT_MAX), .q(sec_o), .q_next(n_sec_o), .carry(c_sec_o)
  );
  bcd_digit_counter u_sec_t (
    .clk(clk), .rst(rst), .en(c_sec_o), .hold(sat), .clr(clear_p),
    .modulus(SEC_T_MAX), .q(sec_t), .q_next(n_sec_t), .carry(c_sec_t)
  );
  bcd_digit_counter u_min (
    .clk(clk), .rst(rst), .en(c_sec_t), .hold(sat), .clr(clear_p),
    .modulus(MIN_MOD), .q(min_d), .q_next(n_min), .carry(c_min)
  );

  // Limit is reached when the incremented value lands exactly on lim:00.0.
  assign limit_hit = count_req && !sat &&
                     ((lim_min_q != 4'd0) || (lim_sec_t_q != 3'd0)) &&
                     (n_min == lim_min_q) && (n_sec_t == {1'b0, lim_sec_t_q}) &&
                     (n_sec_o == 4'd0) && (n_tenth == 4'd0);

  // BCD digits weigh like hex nibbles, so a plain 16-bit compare orders times.
  assign best_load = fin &&
    (!best_valid ||
     ({min_d, sec_t, sec_o, tenth} < {best_min, best_sec_t, best_sec_o, best_tenth}));

  // NOTE: every output of this block gets a default first so no path leaves
  // a variable unassigned and infers a latch.
  always_comb begin
    state_n   = state;
    lim_load  = 1'b0;
    fin       = 1'b0;
    limit_set = 1'b0;
    if (clear_p) begin
      state_n = S_IDLE;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (start_p) begin
            state_n  = S_RUN;
            lim_load = 1'b1;
          end
        end
        S_RUN: begin
          if (finish_p) begin
            state_n = S_DONE;
            fin     = 1'b1;
          end else if (sat || limit_hit) begin
            state_n   = S_DONE;
            limit_set = 1'b1;
          end else if (pause_p) begin
            state_n = S_PAUSE;
          end
        end
        S_PAUSE: begin
          if (finish_p) begin
            state_n = S_DONE;
            fin     = 1'b1;
          end else if (start_p) begin
            state_n = S_RUN;
          end
        end
        S_DONE: state_n = S_DONE;
        default: state_n = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= S_IDLE;
      lim_min_q   <= '0;
      lim_sec_t_q <= '0;
      limit_flag  <= 1'b0;
      new_best    <= 1'b0;
      best_valid  <= 1'b0;
      best_min    <= '0;
      best_sec_t  <= '0;
      best_sec_o  <= '0;
      best_tenth  <= '0;
    end else begin
      state    <= state_n;
      new_best <= best_load;
      if (lim_load) begin
        lim_min_q   <= lim_min;
        lim_sec_t_q <= lim_sec_t;
      end
      if (clear_p)        limit_flag <= 1'b0;
      else if (limit_set) limit_flag <= 1'b1;
      if (best_load) begin
        best_valid <= 1'b1;
        best_min   <= min_d;
        best_sec_t <= sec_t;
        best_sec_o <= sec_o;
        best_tenth <= tenth;
      end
    end
  end

  assign running = (state == S_RUN);
  assign paused  = (state == S_PAUSE);
  assign done    = (state == S_DONE);

endmodule

// File: tb/tb_elapsed_timer.sv
// ---------------------------------------------------------------------------
// tb_elapsed_timer
// Directed bench for elapsed_timer: one default instance (MAX_MIN=9) and one
// MAX_MIN=1 instance for saturation, both driven by the same stimulus.
// Times are compared as packed BCD, e.g. 0:12.5 == 16'h0125.
// ---------------------------------------------------------------------------
module tb_elapsed_timer;

  logic       clk = 1'b0;
  logic       rst;
  logic       tick_100ms, start_p, pause_p, finish_p, clear_p;
  logic [3:0] lim_min;
  logic [2:0] lim_sec_t;

  logic [3:0] min_d, sec_t, sec_o, tenth;
  logic       running, paused, done, limit_flag;
  logic [3:0] best_min, best_sec_t, best_sec_o, best_tenth;
  logic       best_valid, new_best;

  logic [3:0] min_d2, sec_t2, sec_o2, tenth2;
  logic       running2, paused2, done2, limit_flag2;
  logic [3:0] best_min2, best_sec_t2, best_sec_o2, best_tenth2;
  logic       best_valid2, new_best2;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  elapsed_timer dut (
    .clk(clk), .rst(rst), .tick_100ms(tick_100ms),
    .start_p(start_p), .pause_p(pause_p), .finish_p(finish_p), .clear_p(clear_p),
    .lim_min(lim_min), .lim_sec_t(lim_sec_t),
    .min_d(min_d), .sec_t(sec_t), .sec_o(sec_o), .tenth(tenth),
    .running(running), .paused(paused), .done(done), .limit_flag(limit_flag),
    .best_min(best_min), .best_sec_t(best_sec_t), .best_sec_o(best_sec_o),
    .best_tenth(best_tenth), .best_valid(best_valid), .new_best(new_best)
  );

  elapsed_timer #(.MAX_MIN(1)) dut2 (
    .clk(clk), .rst(rst), .tick_100ms(tick_100ms),
    .start_p(start_p), .pause_p(pause_p), .finish_p(finish_p), .clear_p(clear_p),
    .lim_min(lim_min), .lim_sec_t(lim_sec_t),
    .min_d(min_d2), .sec_t(sec_t2), .sec_o(sec_o2), .tenth(tenth2),
    .running(running2), .paused(paused2), .done(done2), .limit_flag(limit_flag2),
    .best_min(best_min2), .best_sec_t(best_sec_t2), .best_sec_o(best_sec_o2),
    .best_tenth(best_tenth2), .best_valid(best_valid2), .new_best(new_best2)
  );

  // Packed views: time, {running,paused,done,limit_flag}, {best_valid,best,new_best}.
  wire [15:0] t1  = {min_d, sec_t, sec_o, tenth};
  wire [3:0]  st1 = {running, paused, done, limit_flag};
  wire [17:0] b1  = {best_valid, best_min, best_sec_t, best_sec_o, best_tenth, new_best};
  wire [15:0] t2  = {min_d2, sec_t2, sec_o2, tenth2};
  wire [3:0]  st2 = {running2, paused2, done2, limit_flag2};
  wire [17:0] b2  = {best_valid2, best_min2, best_sec_t2, best_sec_o2, best_tenth2, new_best2};

  // Apply one cycle of inputs at a falling edge; outputs are then read at the
  // next falling edge, half a period after the rising edge that consumed them.
  task automatic step(input logic t, input logic s, input logic p,
                      input logic f, input logic c);
    tick_100ms = t; start_p = s; pause_p = p; finish_p = f; clear_p = c;
    @(negedge clk);
    tick_100ms = 0; start_p = 0; pause_p = 0; finish_p = 0; clear_p = 0;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) step(1, 0, 0, 0, 0);
  endtask

  task automatic test_reset;
    rst = 1'b0;
    tick_100ms = 0; start_p = 0; pause_p = 0; finish_p = 0; clear_p = 0;
    lim_min = 4'd0; lim_sec_t = 3'd0;
    #2;
    vectors++;
    if (t1 !== 16'h0000) begin
      miscompares++; $display("FAIL reset_time got %h want %h", t1, 16'h0000);
    end
    vectors++;
    if (st1 !== 4'b0000) begin
      miscompares++; $display("FAIL reset_status got %b want %b", st1, 4'b0000);
    end
    vectors++;
    if (b1 !== 18'h0) begin
      miscompares++; $display("FAIL reset_best got %h want %h", b1, 18'h0);
    end
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    step(0, 0, 0, 1, 0);  // finish in IDLE is ignored
    step(0, 0, 1, 0, 0);  // pause in IDLE is ignored
    vectors++;
    if (st1 !== 4'b0000) begin
      miscompares++; $display("FAIL idle_ignore got %b want %b", st1, 4'b0000);
    end
  endtask

  task automatic test_first_run;
    step(0, 1, 0, 0, 0);
    ticks(125);
    vectors++;
    if (st1 !== 4'b1000) begin
      miscompares++; $display("FAIL first_running got %b want %b", st1, 4'b1000);
    end
    step(0, 0, 0, 1, 0);
    vectors++;
    if (t1 !== 16'h0125) begin
      miscompares++; $display("FAIL first_time got %h want %h", t1, 16'h0125);
    end
    vectors++;
    if (st1 !== 4'b0010) begin
      miscompares++; $display("FAIL first_status got %b want %b", st1, 4'b0010);
    end
    vectors++;
    if (b1 !== {1'b1, 16'h0125, 1'b1}) begin
      miscompares++; $display("FAIL first_best got %h want %h", b1, {1'b1, 16'h0125, 1'b1});
    end
    step(0, 0, 0, 0, 0);
    vectors++;
    if (new_best !== 1'b0) begin
      miscompares++; $display("FAIL first_pulse_width got %b want %b", new_best, 1'b0);
    end
  endtask

  task automatic test_slower_run;
    step(0, 0, 0, 0, 1);
    vectors++;
    if ({t1, st1} !== {16'h0000, 4'b0000}) begin
      miscompares++; $display("FAIL clear_state got %h want %h", {t1, st1}, {16'h0000, 4'b0000});
    end
    step(0, 1, 0, 0, 0);
    ticks(200);
    step(0, 0, 0, 1, 0);
    vectors++;
    if ({t1, st1} !== {16'h0200, 4'b0010}) begin
      miscompares++; $display("FAIL slow_final got %h want %h", {t1, st1}, {16'h0200, 4'b0010});
    end
    vectors++;
    if (b1 !== {1'b1, 16'h0125, 1'b0}) begin
      miscompares++; $display("FAIL slow_best got %h want %h", b1, {1'b1, 16'h0125, 1'b0});
    end
  endtask

  task automatic test_limit;
    step(0, 0, 0, 0, 1);
    lim_min = 4'd0; lim_sec_t = 3'd3;
    step(0, 1, 0, 0, 0);
    lim_min = 4'd0; lim_sec_t = 3'd0;  // held values must still apply
    ticks(299);
    vectors++;
    if ({t1, st1} !== {16'h0299, 4'b1000}) begin
      miscompares++; $display("FAIL limit_before got %h want %h", {t1, st1}, {16'h0299, 4'b1000});
    end
    ticks(1);
    vectors++;
    if ({t1, st1} !== {16'h0300, 4'b0011}) begin
      miscompares++; $display("FAIL limit_hit got %h want %h", {t1, st1}, {16'h0300, 4'b0011});
    end
    ticks(1);
    vectors++;
    if ({t1, st1} !== {16'h0300, 4'b0011}) begin
      miscompares++; $display("FAIL limit_hold got %h want %h", {t1, st1}, {16'h0300, 4'b0011});
    end
    vectors++;
    if (b1 !== {1'b1, 16'h0125, 1'b0}) begin
      miscompares++; $display("FAIL limit_best got %h want %h", b1, {1'b1, 16'h0125, 1'b0});
    end
  endtask

  task automatic test_pause;
    step(0, 0, 0, 0, 1);
    vectors++;
    if (limit_flag !== 1'b0) begin
      miscompares++; $display("FAIL clear_limit_flag got %b want %b", limit_flag, 1'b0);
    end
    step(0, 1, 0, 0, 0);
    ticks(59);
    step(1, 0, 1, 0, 0);
    vectors++;
    if ({t1, st1} !== {16'h0060, 4'b0100}) begin
      miscompares++; $display("FAIL pause_tick got %h want %h", {t1, st1}, {16'h0060, 4'b0100});
    end
    ticks(10);
    vectors++;
    if ({t1, st1} !== {16'h0060, 4'b0100}) begin
      miscompares++; $display("FAIL pause_hold got %h want %h", {t1, st1}, {16'h0060, 4'b0100});
    end
    step(0, 1, 0, 0, 0);
    ticks(1);
    vectors++;
    if ({t1, st1} !== {16'h0061, 4'b1000}) begin
      miscompares++; $display("FAIL pause_resume got %h want %h", {t1, st1}, {16'h0061, 4'b1000});
    end
  endtask

  task automatic test_back_to_back;
    step(0, 0, 0, 0, 1);
    step(0, 1, 0, 0, 0);
    ticks(42);
    step(1, 0, 0, 1, 0);
    vectors++;
    if ({t1, st1} !== {16'h0042, 4'b0010}) begin
      miscompares++; $display("FAIL finish_tick got %h want %h", {t1, st1}, {16'h0042, 4'b0010});
    end
    vectors++;
    if (b1 !== {1'b1, 16'h0042, 1'b1}) begin
      miscompares++; $display("FAIL better_best got %h want %h", b1, {1'b1, 16'h0042, 1'b1});
    end
    step(1, 1, 1, 0, 0);
    step(0, 0, 0, 1, 0);
    vectors++;
    if ({t1, st1, new_best} !== {16'h0042, 4'b0010, 1'b0}) begin
      miscompares++;
      $display("FAIL done_ignore got %h want %h", {t1, st1, new_best}, {16'h0042, 4'b0010, 1'b0});
    end
    step(0, 1, 0, 0, 1);
    vectors++;
    if ({t1, st1} !== {16'h0000, 4'b0000}) begin
      miscompares++; $display("FAIL clear_start got %h want %h", {t1, st1}, {16'h0000, 4'b0000});
    end
    vectors++;
    if (b1 !== {1'b1, 16'h0042, 1'b0}) begin
      miscompares++; $display("FAIL clear_keeps_best got %h want %h", b1, {1'b1, 16'h0042, 1'b0});
    end
  endtask

  task automatic test_saturation;
    step(0, 1, 0, 0, 0);
    ticks(1199);
    vectors++;
    if ({t2, st2} !== {16'h1599, 4'b1000}) begin
      miscompares++; $display("FAIL sat_before got %h want %h", {t2, st2}, {16'h1599, 4'b1000});
    end
    ticks(1);
    vectors++;
    if ({t2, st2} !== {16'h1599, 4'b0011}) begin
      miscompares++; $display("FAIL sat_hold got %h want %h", {t2, st2}, {16'h1599, 4'b0011});
    end
    vectors++;
    if ({t1, st1} !== {16'h2000, 4'b1000}) begin
      miscompares++; $display("FAIL minute_roll got %h want %h", {t1, st1}, {16'h2000, 4'b1000});
    end
    step(0, 0, 0, 0, 1);
    step(0, 1, 0, 0, 0);
    ticks(5);
    rst = 1'b0;
    #1;
    vectors++;
    if ({t1, st1, b1} !== 38'h0) begin
      miscompares++; $display("FAIL rst_midrun got %h want %h", {t1, st1, b1}, 38'h0);
    end
    vectors++;
    if ({t2, st2, b2} !== 38'h0) begin
      miscompares++; $display("FAIL rst_midrun2 got %h want %h", {t2, st2, b2}, 38'h0);
    end
    @(negedge clk);
    rst = 1'b1;
  endtask

  initial begin
    test_reset();
    test_first_run();
    test_slower_run();
    test_limit();
    test_pause();
    test_back_to_back();
    test_saturation();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/elapsed_timer.md
ELAPSED_TIMER -- requirements
Module: elapsed_timer

Interface
REQ-001 Parameter MAX_MIN, default 9, SHALL set the highest minute value (BCD, 1..9).
REQ-002 clk  input  1  system clock; all state SHALL change on its rising edge except reset.
REQ-003 rst  input  1  reset, asynchronous, active-low.
REQ-004 tick_100ms  input  1  one-clk-wide enable pulse, once per 100 ms.
REQ-005 start_p / pause_p / finish_p / clear_p  input  1 each  one-clk-wide command pulses.
REQ-006 lim_min  input  4  minute limit, BCD 0..MAX_MIN; lim_sec_t  input  3  seconds-tens limit, 0..5; 0:00 SHALL mean no limit.
REQ-007 min_d, sec_t, sec_o, tenth  output  4 each  elapsed time, BCD.
REQ-008 running, paused, done  output  1 each  state decode.
REQ-009 limit_flag  output  1  run ended by limit or saturation.
REQ-010 best_min, best_sec_t, best_sec_o, best_tenth  output  4 each  best (lowest) finish time; best_valid  output  1.
REQ-011 new_best  output  1  one-clk pulse when best is updated.

Function
REQ-012 FSM states IDLE, RUN, PAUSE, DONE; running/paused/done SHALL be 1 only in RUN/PAUSE/DONE.
REQ-013 Command priority, same cycle: clear_p > finish_p > pause_p > start_p.
REQ-014 clear_p in any state -> IDLE, elapsed digits 0, limit_flag 0; best registers unchanged.
REQ-015 IDLE: start_p -> RUN from 0:00.0; other commands ignored.
REQ-016 RUN: each tick_100ms SHALL increment elapsed by 0.1 s on the same edge (ripple tenth 9->0, sec_o 9->0, sec_t 5->0, min +1).
REQ-017 RUN: pause_p -> PAUSE; a tick in the same cycle SHALL still be counted.
REQ-018 PAUSE: ticks ignored; start_p -> RUN resuming held value; finish_p -> DONE.
REQ-019 RUN/PAUSE: finish_p -> DONE; a tick in the same cycle SHALL NOT be counted; held value is the final time.
REQ-020 On finish_p, if best_valid=0 or final < best (BCD magnitude compare), best SHALL load final, best_valid 1, new_best pulse next edge.
REQ-021 Limit: when an increment produces min_d=lim_min, sec_t=lim_sec_t, sec_o=0, tenth=0 (limit nonzero), the FSM SHALL enter DONE on that edge with limit_flag 1; best not updated.
REQ-022 Saturation: tick at MAX_MIN:59.9 SHALL NOT wrap; value holds, DONE, limit_flag 1.
REQ-023 DONE: outputs hold; only clear_p acts; start_p, pause_p, finish_p ignored.
REQ-024 lim_min/lim_sec_t SHALL be sampled at start_p from IDLE and held for the run.
REQ-025 Digits SHALL never hold non-BCD values; sec_t SHALL never exceed 5.

Reset
REQ-026 rst low SHALL force IDLE, all elapsed and best digits 0, best_valid 0, limit_flag 0, new_best 0, held limit 0:00, immediately and independent of clk.
REQ-027 rst asserted mid-run SHALL abandon the run; no best update.

Structure
REQ-028 Package elapsed_timer_pkg SHALL hold the FSM state enum, 4-bit BCD digit type, and constants SEC_T_MAX=5, DIGIT_MAX=9.
REQ-029 One sub-module bcd_digit_counter (enable, clear, modulus, carry-out) SHALL be instantiated per elapsed digit.
REQ-030 Best-time compare SHALL be combinational over the 16-bit concatenated BCD value.

Verification
REQ-031 Reset, start_p, 125 ticks, finish_p -> 0:12.5, done=1, best=0:12.5, best_valid=1, new_best one clk.
REQ-032 clear_p, start_p, 200 ticks, finish_p -> 0:20.0 final, best stays 0:12.5, new_best stays 0.
REQ-033 lim_min=0, lim_sec_t=3, start_p, 300 ticks -> 0:30.0, DONE, limit_flag=1 on tick 300; tick 301 no change.
REQ-034 RUN 0:05.9, tick+pause_p same cycle -> 0:06.0 PAUSE; 10 ticks -> still 0:06.0; start_p, 1 tick -> 0:06.1.
REQ-035 RUN, tick+finish_p same cycle at 0:04.2 -> final 0:04.2; clear_p+start_p same cycle -> IDLE, 0:00.0.
REQ-036 MAX_MIN=1, no limit, 1199 ticks -> 1:59.9 RUN; next tick -> hold 1:59.9, DONE, limit_flag=1; rst mid-run -> all zero, best_valid 0.
